pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

- Central stall/flush/freeze controller for the 5-stage RV32 pipeline.
- Watches the ID, EX and MEM stages and drives the hold, bubble and flush controls of the PC register, the IF/ID latch, the ID/EX latch (its `stop` and `branch_reset` inputs), the EX/MEM latch and the MEM/WB latch.
- Also owns the data-memory wait freeze with timeout and the debug halt/single-step sequencing.

## Interface
Parameters:
- `MEM_TIMEOUT`, default 255: maximum number of MEM_WAIT cycles before the freeze is abandoned; legal range 1..255.

Ports:
- `clk`  in  1: pipeline clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `id_rs1`  in  5: rs1 field of the instruction in IF/ID.
- `id_rs2`  in  5: rs2 field of the instruction in IF/ID.
- `id_use_rs2`  in  1: the ID instruction reads rs2.
- `ex_memread`  in  1: the ID/EX instruction is a load.
- `ex_rd`  in  5: destination register of the ID/EX instruction.
- `branch_taken`  in  1: EX resolved a taken branch or jump.
- `mem_req`  in  1: the MEM stage has a data-memory access this cycle.
- `mem_ack`  in  1: the data memory completes the access this cycle.
- `halt_req`  in  1: debug halt request, level-sensitive.
- `step`  in  1: single-step pulse, honoured only in HALT.
- `pc_hold`  out  1: hold the PC.
- `ifid_hold`  out  1: hold the IF/ID latch.
- `ifid_flush`  out  1: clear the IF/ID latch.
- `idex_stop`  out  1: insert a bubble into ID/EX (drives the latch's `stop`).
- `idex_flush`  out  1: clear ID/EX (drives the latch's `branch_reset`).
- `exmem_hold`  out  1: hold the EX/MEM latch.
- `memwb_bubble`  out  1: write a bubble into MEM/WB.
- `halted`  out  1: controller is in HALT.
- `mem_timeout`  out  1: one-cycle pulse when the freeze is abandoned.
- `stall_cnt`  out  16: count of load-use stall cycles.
- `flush_cnt`  out  16: count of branch-flush cycles.

## Operation
FSM states: RUN, MEM_WAIT, HALT, STEP. Reset state is RUN.

Per-cycle conditions:
- freeze = (state==MEM_WAIT & !mem_ack) | (state!=MEM_WAIT & mem_req & !mem_ack).
- lu = ex_memread & ex_rd!=0 & (ex_rd==id_rs1 | (id_use_rs2 & ex_rd==id_rs2)).

Outputs are Mealy, resolved in priority order; all outputs not named are 0:
1. freeze: pc_hold, ifid_hold, exmem_hold, memwb_bubble = 1. ID/EX holds by idex_stop=0 and idex_flush=0 with the EX stage frozen upstream; branch and load-use are suppressed.
2. branch_taken: ifid_flush = 1, idex_flush = 1.
3. lu: pc_hold, ifid_hold, idex_stop = 1.
4. state==HALT: pc_hold, ifid_hold, idex_stop = 1, so the back end drains.

`halted` = (state==HALT).

Transitions:
- RUN: freeze → MEM_WAIT, wait_cnt←0. Else halt_req & !branch_taken → HALT.
- MEM_WAIT:
  - mem_ack → RUN.
  - !mem_ack & wait_cnt==MEM_TIMEOUT-1 → RUN, and mem_timeout=1 on the next cycle.
  - Otherwise wait_cnt+1.
- HALT: freeze → MEM_WAIT. Else !halt_req → RUN. Else step → STEP.
- STEP: outputs as RUN for exactly one cycle. Then freeze → MEM_WAIT, else halt_req → HALT, else RUN.
- MEM_WAIT always exits to RUN; a still-high halt_req re-enters HALT on the following cycle.

## Timing
- Reset values: state=RUN, wait_cnt=0, mem_timeout=0, stall_cnt=0, flush_cnt=0.
- While reset is low, every hold/flush/bubble output is 0.
- Load-use costs 1 cycle. The bubble clears ex_memread, so the stall self-terminates.
- A branch flush is asserted in the same cycle branch_taken is seen, for 1 cycle.
- Zero-wait access (mem_req & mem_ack in the same cycle): no freeze.
- Maximum freeze length: MEM_TIMEOUT+1 cycles (1 entry cycle plus MEM_TIMEOUT cycles in MEM_WAIT).
- mem_ack in the last MEM_WAIT cycle takes priority over timeout; mem_timeout stays 0.
- branch_taken during a freeze is not lost: EX is held, so the branch is re-presented and applied in the first unfrozen cycle.
- Simultaneous branch_taken and lu: the flush wins; pc_hold=0 so the PC takes the branch target.
- Reset asserted mid-operation: returns to RUN immediately and all outputs go to 0 asynchronously.

## Configuration
Macro `PIPE_PERF_CNT_EN`:
- Defined: each counter increments once per cycle in which its event is the winning output case. stall_cnt counts lu; flush_cnt counts branch. Both saturate at 16'hFFFF.
- Undefined: stall_cnt and flush_cnt are tied to 0 and no counter flops are built. Ports are present in both builds.

## Test plan
- Load-use: ex_memread=1, ex_rd=5, id_rs1=5 for one cycle → pc_hold, ifid_hold, idex_stop =1 for 1 cycle. With ex_rd=0 → no stall.
- Branch plus hazard in the same cycle: branch_taken=1 with lu true → ifid_flush=idex_flush=1, pc_hold=0, idex_stop=0. flush_cnt +1, stall_cnt unchanged (macro on).
- Memory wait: mem_req=1, mem_ack after 3 cycles → freeze outputs high for 3 cycles, then 0 in the ack cycle; mem_timeout stays 0.
- Timeout with MEM_TIMEOUT=4: mem_req=1 held, no ack → 5 frozen cycles, then mem_timeout=1 for exactly 1 cycle, state RUN.
- Debug: halt_req=1 → halted=1 the next cycle. A step pulse → exactly one cycle without pc_hold, then halted=1 again. Drop halt_req → RUN.
- Reset: assert reset low while in MEM_WAIT with wait_cnt=2 → all outputs 0 immediately. After release: state RUN, counters 0.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush/freeze controller for the 5-stage RV32 pipeline.
// Optional feature macro: PIPE_PERF_CNT_EN builds saturating stall/flush event counters.
module pipe_hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_use_rs2,
    input  logic        ex_memread,
    input  logic [4:0]  ex_rd,
    input  logic        branch_taken,
    input  logic        mem_req,
    input  logic        mem_ack,
    input  logic        halt_req,
    input  logic        step,
    output logic        pc_hold,
    output logic        ifid_hold,
    output logic        ifid_flush,
    output logic        idex_stop,
    output logic        idex_flush,
    output logic        exmem_hold,
    output logic        memwb_bubble,
    output logic        halted,
    output logic        mem_timeout,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_HALT     = 2'd2,
        ST_STEP     = 2'd3
    } state_e;

    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_e     state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       mem_timeout_q, mem_timeout_d;
    logic       in_wait;
    logic       freeze;
    logic       load_use;

    // mem_req/mem_ack: the access is outstanding from the first cycle mem_req is
    // high until the cycle mem_ack is high; an ack in the request cycle costs nothing.
    assign in_wait  = (state_q == ST_MEM_WAIT);
    assign freeze   = in_wait ? !mem_ack : (mem_req && !mem_ack);
    assign load_use = ex_memread && (ex_rd != 5'd0) &&
                      ((ex_rd == id_rs1) || (id_use_rs2 && (ex_rd == id_rs2)));

    // Gating with reset makes every control drop asynchronously while reset is low.
    always_comb begin
        pc_hold      = 1'b0;
        ifid_hold    = 1'b0;
        ifid_flush   = 1'b0;
        idex_stop    = 1'b0;
        idex_flush   = 1'b0;
        exmem_hold   = 1'b0;
        memwb_bubble = 1'b0;
        if (reset) begin
            if (freeze) begin
                pc_hold      = 1'b1;
                ifid_hold    = 1'b1;
                exmem_hold   = 1'b1;
                memwb_bubble = 1'b1;
            end else if (branch_taken) begin
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end else if (load_use || (state_q == ST_HALT)) begin
                pc_hold   = 1'b1;
                ifid_hold = 1'b1;
                idex_stop = 1'b1;
            end
        end
    end

    assign halted      = (state_q == ST_HALT);
    assign mem_timeout = mem_timeout_q;

    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        mem_timeout_d = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (freeze) begin
                    state_d    = ST_MEM_WAIT;
                    wait_cnt_d = 8'd0;
                end else if (halt_req && !branch_taken) begin
                    state_d = ST_HALT;
                end
            end
            ST_MEM_WAIT: begin
                if (mem_ack) begin
                    state_d = ST_RUN;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d       = ST_RUN;
                    mem_timeout_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            ST_HALT: begin
                if (freeze) begin
                    state_d    = ST_MEM_WAIT;
                    wait_cnt_d = 8'd0;
                end else if (!halt_req) begin
                    state_d = ST_RUN;
                end else if (step) begin
                    state_d = ST_STEP;
                end
            end
            ST_STEP: begin
                if (freeze) begin
                    state_d    = ST_MEM_WAIT;
                    wait_cnt_d = 8'd0;
                end else if (halt_req) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_RUN;
            wait_cnt_q    <= 8'd0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

`ifdef PIPE_PERF_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;

    // A counter only moves when its event is the winning output case.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!freeze && branch_taken && (flush_cnt_q != 16'hFFFF)) begin
            flush_cnt_d = flush_cnt_q + 16'd1;
        end
        if (!freeze && !branch_taken && load_use && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= 16'd0;
            flush_cnt_q <= 16'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = 16'd0;
    assign flush_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with a flag-based reference model checked every cycle.
module tb_pipe_hazard_ctrl;

    localparam int MT = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
    logic        id_use_rs2 = 0, ex_memread = 0, branch_taken = 0;
    logic        mem_req = 0, mem_ack = 0, halt_req = 0, step = 0;
    logic        pc_hold, ifid_hold, ifid_flush, idex_stop, idex_flush;
    logic        exmem_hold, memwb_bubble, halted, mem_timeout;
    logic [15:0] stall_cnt, flush_cnt;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(MT)) dut (
        .clk(clk), .reset(reset),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs2(id_use_rs2),
        .ex_memread(ex_memread), .ex_rd(ex_rd), .branch_taken(branch_taken),
        .mem_req(mem_req), .mem_ack(mem_ack), .halt_req(halt_req), .step(step),
        .pc_hold(pc_hold), .ifid_hold(ifid_hold), .ifid_flush(ifid_flush),
        .idex_stop(idex_stop), .idex_flush(idex_flush), .exmem_hold(exmem_hold),
        .memwb_bubble(memwb_bubble), .halted(halted), .mem_timeout(mem_timeout),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    // {pc_hold, ifid_hold, ifid_flush, idex_stop, idex_flush, exmem_hold, memwb_bubble}
    localparam logic [6:0] V_FRZ  = 7'b1100011;
    localparam logic [6:0] V_BR   = 7'b0010100;
    localparam logic [6:0] V_STL  = 7'b1101000;
    localparam logic [6:0] V_NONE = 7'b0000000;

    logic [6:0] vec;
    assign vec = {pc_hold, ifid_hold, ifid_flush, idex_stop, idex_flush, exmem_hold, memwb_bubble};

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: waiting/halted/stepping flags plus event counts.
    logic m_wait = 0, m_halt = 0, m_step = 0, m_to = 0;
    int   m_wlen = 0, m_stall = 0, m_flush = 0;
    logic m_frz, m_lu;

    assign m_frz = m_wait ? !mem_ack : (mem_req && !mem_ack);
    assign m_lu  = ex_memread && (ex_rd != 0) &&
                   ((ex_rd == id_rs1) || (id_use_rs2 && (ex_rd == id_rs2)));

    function automatic logic [6:0] model_vec();
        if (!reset) return V_NONE;
        if (m_frz) return V_FRZ;
        if (branch_taken) return V_BR;
        if (m_lu || m_halt) return V_STL;
        return V_NONE;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_wait <= 0; m_halt <= 0; m_step <= 0; m_to <= 0;
            m_wlen <= 0; m_stall <= 0; m_flush <= 0;
        end else begin
            m_to <= 0;
            if (!m_frz && branch_taken && m_flush < 65535) m_flush <= m_flush + 1;
            if (!m_frz && !branch_taken && m_lu && m_stall < 65535) m_stall <= m_stall + 1;
            if (m_wait) begin
                if (mem_ack) m_wait <= 0;
                else if (m_wlen == MT - 1) begin m_wait <= 0; m_to <= 1; end
                else m_wlen <= m_wlen + 1;
            end else if (m_frz) begin
                m_wait <= 1; m_wlen <= 0; m_halt <= 0; m_step <= 0;
            end else if (m_halt) begin
                if (!halt_req) m_halt <= 0;
                else if (step) begin m_halt <= 0; m_step <= 1; end
            end else begin
                m_step <= 0;
                m_halt <= halt_req && (m_step || !branch_taken);
            end
        end
    end

`ifdef PIPE_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    always @(negedge clk) begin
        check("model_vec", vec, model_vec());
        check("model_halted", halted, m_halt);
        check("model_timeout", mem_timeout, m_to);
        check("model_stall_cnt", stall_cnt, PERF ? m_stall : 0);
        check("model_flush_cnt", flush_cnt, PERF ? m_flush : 0);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        mem_req = 1;
        #1 reset = 0;
        #1;
        check("reset_vec", vec, V_NONE);
        check("reset_halted", halted, 0);
        check("reset_timeout", mem_timeout, 0);
        check("reset_stall_cnt", stall_cnt, 0);
        check("reset_flush_cnt", flush_cnt, 0);
        repeat (2) @(posedge clk);
        #3 mem_req = 0;
        reset = 1;
        cyc();

        // Load-use on rs1, then cleared by the bubble
        ex_memread = 1; ex_rd = 5; id_rs1 = 5;
        #1 check("lu_rs1", vec, V_STL);
        cyc();
        ex_memread = 0;
        #1 check("lu_done", vec, V_NONE);
        cyc();
        ex_memread = 1; ex_rd = 0; id_rs1 = 0;
        #1 check("lu_x0", vec, V_NONE);
        cyc();
        ex_rd = 7; id_rs1 = 3; id_rs2 = 7; id_use_rs2 = 1;
        #1 check("lu_rs2", vec, V_STL);
        cyc();
        id_use_rs2 = 0;
        #1 check("lu_rs2_unused", vec, V_NONE);
        cyc();

        // Branch and load-use together: flush wins
        id_rs1 = 7; branch_taken = 1;
        #1 check("br_lu", vec, V_BR);
        cyc();
        branch_taken = 0; ex_memread = 0;
        cyc();

        // 3-cycle memory wait; branch arrives mid-freeze and is applied at ack
        mem_req = 1;
        for (int i = 0; i < 3; i++) begin
            if (i == 1) branch_taken = 1;
            #1 check("mem_freeze", vec, V_FRZ);
            cyc();
        end
        mem_ack = 1;
        #1 check("mem_ack_branch", vec, V_BR);
        cyc();
        mem_req = 0; mem_ack = 0; branch_taken = 0;
        #1 check("mem_no_timeout", mem_timeout, 0);
        check("mem_after", vec, V_NONE);
        cyc();

        // Zero-wait access
        mem_req = 1; mem_ack = 1;
        #1 check("zero_wait", vec, V_NONE);
        cyc();
        mem_req = 0; mem_ack = 0;
        cyc();

        // Timeout: MT+1 frozen cycles then a one-cycle pulse
        mem_req = 1;
        for (int i = 0; i < MT + 1; i++) begin
            #1 check("to_freeze", vec, V_FRZ);
            cyc();
        end
        mem_req = 0;
        #1 check("to_pulse", mem_timeout, 1);
        check("to_run_vec", vec, V_NONE);
        cyc();
        #1 check("to_pulse_end", mem_timeout, 0);
        cyc();

        // Debug halt and single step
        halt_req = 1;
        #1 check("halt_req_cycle", halted, 0);
        cyc();
        #1 check("halted", halted, 1);
        check("halt_vec", vec, V_STL);
        step = 1;
        cyc();
        step = 0;
        #1 check("step_halted", halted, 0);
        check("step_vec", vec, V_NONE);
        cyc();
        #1 check("step_rehalt", halted, 1);
        halt_req = 0;
        cyc();
        #1 check("unhalt", halted, 0);
        check("unhalt_vec", vec, V_NONE);
        cyc();

        // Halt request deferred by a branch
        halt_req = 1; branch_taken = 1;
        #1 check("halt_br_vec", vec, V_BR);
        cyc();
        branch_taken = 0;
        #1 check("halt_br_deferred", halted, 0);
        cyc();
        #1 check("halt_br_later", halted, 1);
        halt_req = 0;
        cyc();
        cyc();

        // Reset while in MEM_WAIT with wait count 2
        mem_req = 1;
        repeat (3) cyc();
        #1 check("pre_reset_freeze", vec, V_FRZ);
        reset = 0;
        #1 check("async_reset_vec", vec, V_NONE);
        check("async_reset_halted", halted, 0);
        cyc();
        mem_req = 0;
        reset = 1;
        #1 check("post_reset_vec", vec, V_NONE);
        check("post_reset_stall_cnt", stall_cnt, 0);
        check("post_reset_flush_cnt", flush_cnt, 0);
        check("post_reset_timeout", mem_timeout, 0);
        cyc();
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
